// File: rtl/rainbow_pkg.sv
// Shared definitions for the RGB444 rainbow colour wheel (generator and decoder).
package rainbow_pkg;

  localparam int HUE_STEPS = 90;
  localparam int SEG_LEN   = 15;
  localparam logic [3:0] CH_MAX  = 4'd15;
  localparam logic [6:0] IDX_MAX = 7'(HUE_STEPS - 1);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} trk_state_t;

  // Successor on the wheel, wrapping 89 -> 0.
  function automatic logic [6:0] hue_next(input logic [6:0] i);
    return (i == IDX_MAX) ? 7'd0 : i + 7'd1;
  endfunction

endpackage

// File: rtl/rainbow_hue_lut.sv
// Combinational inverse of the colour wheel: RGB444 sample -> {on_wheel, idx}.
// Each wheel segment ramps exactly one channel while the other two sit at 0/15;
// the segment conditions below are disjoint so the mapping is unique.
module rainbow_hue_lut
  import rainbow_pkg::*;
(
  input  rgb444_t    color,
  output logic       on_wheel,
  output logic [6:0] idx
);

  logic [6:0] r7, g7, b7;
  assign r7 = {3'b000, color.r};
  assign g7 = {3'b000, color.g};
  assign b7 = {3'b000, color.b};

  // Segment select and index arithmetic; off-wheel reports index 0.
  always_comb begin
    on_wheel = 1'b1;
    idx      = 7'd0;
    if (color.r == CH_MAX && color.b == 4'd0 && color.g != CH_MAX)
      idx = g7;
    else if (color.g == CH_MAX && color.b == 4'd0 && color.r != 4'd0)
      idx = 7'd30 - r7;
    else if (color.r == 4'd0 && color.g == CH_MAX && color.b != CH_MAX)
      idx = 7'd30 + b7;
    else if (color.b == CH_MAX && color.r == 4'd0 && color.g != 4'd0)
      idx = 7'd60 - g7;
    else if (color.g == 4'd0 && color.b == CH_MAX && color.r != CH_MAX)
      idx = 7'd60 + r7;
    else if (color.r == CH_MAX && color.g == 4'd0 && color.b != 4'd0)
      idx = 7'd90 - b7;
    else
      on_wheel = 1'b0;
  end

endmodule

// File: rtl/rainbow_hue_decoder.sv
// Rainbow hue decoder: decodes RGB444 samples to wheel index, tracks +1 steps,
// reports lock and sequence breaks. Optional HUE_DEGREES_EN adds hue_deg = idx*4.
module rainbow_hue_decoder
  import rainbow_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter bit ALLOW_HOLD = 1'b1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        color_valid,
  input  logic [11:0] color,
  output logic        hue_valid,
  output logic [6:0]  hue_idx,
  output logic        on_wheel,
  output logic        locked,
  output logic        step_err
`ifdef HUE_DEGREES_EN
  ,
  output logic [8:0]  hue_deg
`endif
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  rgb444_t    c;
  logic       lut_on;
  logic [6:0] lut_idx;

  assign c = color;

  rainbow_hue_lut u_lut (
    .color    (c),
    .on_wheel (lut_on),
    .idx      (lut_idx)
  );

  trk_state_t state, state_nxt;
  logic [6:0] last_idx, last_nxt;
  logic [3:0] good_cnt, cnt_nxt;
  logic       err_nxt;
  logic       good;
  logic [1:0] vld_pipe;

  assign good = (lut_idx == hue_next(last_idx)) ||
                (ALLOW_HOLD && (lut_idx == last_idx));

  // Tracker next-state: only advances on a valid sample.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_idx;
    cnt_nxt   = good_cnt;
    err_nxt   = 1'b0;
    if (color_valid) begin
      if (lut_on) last_nxt = lut_idx;
      case (state)
        SEEK: begin
          if (lut_on) begin
            state_nxt = TRACK;
            cnt_nxt   = 4'd0;
          end
        end
        TRACK: begin
          if (!lut_on) begin
            state_nxt = SEEK;
            err_nxt   = 1'b1;
            cnt_nxt   = 4'd0;
          end else if (good) begin
            // In TRACK the count is below LOCK_CNT, so +1 cannot overflow.
            cnt_nxt = good_cnt + 4'd1;
            if (cnt_nxt == LOCK_CNT) state_nxt = LOCKED;
          end else begin
            err_nxt = 1'b1;
            cnt_nxt = 4'd0;
          end
        end
        LOCKED: begin
          // Good steps keep the count saturated at LOCK_CNT.
          if (!lut_on) begin
            state_nxt = SEEK;
            err_nxt   = 1'b1;
            cnt_nxt   = 4'd0;
          end else if (!good) begin
            state_nxt = TRACK;
            err_nxt   = 1'b1;
            cnt_nxt   = 4'd0;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEEK;
      last_idx <= 7'd0;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      last_idx <= last_nxt;
      good_cnt <= cnt_nxt;
    end
  end

  assign vld_pipe[0] = color_valid;
  assign hue_valid   = vld_pipe[1];

  // Output registers: valid/err pulse every cycle, result fields hold between samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      step_err    <= 1'b0;
      hue_idx     <= 7'd0;
      on_wheel    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      step_err    <= err_nxt;
      if (color_valid) begin
        hue_idx  <= lut_idx;
        on_wheel <= lut_on;
        locked   <= (state_nxt == LOCKED);
      end
    end
  end

`ifdef HUE_DEGREES_EN
  // Degrees view of the index, kept in step with hue_idx.
  always_ff @(posedge clk) begin
    if (reset)            hue_deg <= 9'd0;
    else if (color_valid) hue_deg <= {lut_idx, 2'b00};
  end
`endif

endmodule

// File: tb/tb_rainbow_hue_decoder.sv
// Bench for rainbow_hue_decoder: two instances (hold allowed / not allowed)
// against a run-length reference model built from the wheel generator.
module tb_rainbow_hue_decoder;

  localparam int LC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        color_valid = 1'b0;
  logic [11:0] color = 12'h000;

  logic       hv1, ow1, lk1, se1, hv0, ow0, lk0, se0;
  logic [6:0] hi1, hi0;
`ifdef HUE_DEGREES_EN
  logic [8:0] hd1, hd0;
`endif

  always #5 clk = ~clk;

  rainbow_hue_decoder #(.LOCK_COUNT(LC), .ALLOW_HOLD(1'b1)) d1 (
    .clk(clk), .reset(reset), .color_valid(color_valid), .color(color),
    .hue_valid(hv1), .hue_idx(hi1), .on_wheel(ow1), .locked(lk1), .step_err(se1)
`ifdef HUE_DEGREES_EN
    , .hue_deg(hd1)
`endif
  );

  rainbow_hue_decoder #(.LOCK_COUNT(LC), .ALLOW_HOLD(1'b0)) d0 (
    .clk(clk), .reset(reset), .color_valid(color_valid), .color(color),
    .hue_valid(hv0), .hue_idx(hi0), .on_wheel(ow0), .locked(lk0), .step_err(se0)
`ifdef HUE_DEGREES_EN
    , .hue_deg(hd0)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Wheel generator straight from the segment description.
  function automatic logic [11:0] gen(input int i);
    int k, s;
    logic [3:0] kk, ik;
    k  = i % 15;
    s  = (i / 15) % 6;
    kk = 4'(k);
    ik = 4'(15 - k);
    case (s)
      0:       return {4'hF, kk,   4'h0};
      1:       return {ik,   4'hF, 4'h0};
      2:       return {4'h0, 4'hF, kk};
      3:       return {4'h0, ik,   4'hF};
      4:       return {kk,   4'h0, 4'hF};
      default: return {4'hF, 4'h0, ik};
    endcase
  endfunction

  // Reference decode: inverse of the generator, -1 for off-wheel colours.
  int dec [4096];
  initial begin
    for (int c = 0; c < 4096; c++) dec[c] = -1;
    for (int i = 0; i < 90; i++) dec[gen(i)] = i;
  end

  // Reference tracker per instance (index 1 = holds allowed): a run length of
  // consecutive good steps since the first on-wheel sample.
  bit have_prev [2];
  int prev [2];
  int run [2];
  logic       e_hv [2];
  logic       e_ow [2];
  logic       e_lk [2];
  logic       e_err [2];
  int         e_idx [2];
  logic [11:0] smp_c;

  initial
    for (int m = 0; m < 2; m++) begin
      have_prev[m] = 0; prev[m] = 0; run[m] = 0;
      e_hv[m] = 0; e_ow[m] = 0; e_lk[m] = 0; e_err[m] = 0; e_idx[m] = 0;
    end

  always @(posedge clk) begin
    smp_c = color;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        have_prev[m] = 0; prev[m] = 0; run[m] = 0;
        e_hv[m] = 0; e_ow[m] = 0; e_lk[m] = 0; e_err[m] = 0; e_idx[m] = 0;
      end else if (color_valid) begin
        int d;
        d = dec[color];
        e_hv[m]  = 1;
        e_err[m] = 0;
        if (d < 0) begin
          e_ow[m] = 0; e_idx[m] = 0;
          e_err[m] = have_prev[m];
          have_prev[m] = 0; run[m] = 0;
        end else begin
          e_ow[m] = 1; e_idx[m] = d;
          if (!have_prev[m]) begin
            have_prev[m] = 1; run[m] = 0;
          end else if (d == (prev[m] + 1) % 90 || (m == 1 && d == prev[m])) begin
            run[m] = (run[m] < LC) ? run[m] + 1 : LC;
          end else begin
            e_err[m] = 1; run[m] = 0;
          end
          prev[m] = d;
        end
        e_lk[m] = have_prev[m] && run[m] >= LC;
      end else begin
        e_hv[m] = 0; e_err[m] = 0;
      end
    end
  end

  // Sweep bookkeeping.
  bit sweep_en = 0;
  int hits = 0;
  int seen [90];
  int lutmap [4096];
  initial for (int i = 0; i < 90; i++) seen[i] = 0;

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("hue_valid_h1", hv1, e_hv[1]);
    chk("hue_idx_h1",   hi1, e_idx[1]);
    chk("on_wheel_h1",  ow1, e_ow[1]);
    chk("locked_h1",    lk1, e_lk[1]);
    chk("step_err_h1",  se1, e_err[1]);
    chk("hue_valid_h0", hv0, e_hv[0]);
    chk("hue_idx_h0",   hi0, e_idx[0]);
    chk("on_wheel_h0",  ow0, e_ow[0]);
    chk("locked_h0",    lk0, e_lk[0]);
    chk("step_err_h0",  se0, e_err[0]);
`ifdef HUE_DEGREES_EN
    chk("hue_deg_h1", hd1, e_idx[1] * 4);
    chk("hue_deg_h0", hd0, e_idx[0] * 4);
`endif
    if (sweep_en && hv1) begin
      if (ow1) begin
        hits++;
        seen[hi1]++;
        lutmap[smp_c] = int'(hi1);
      end else lutmap[smp_c] = -1;
    end
  end

  task automatic send(input logic [11:0] c);
    color_valid = 1'b1;
    color = c;
    @(posedge clk); #1;
    color_valid = 1'b0;
  endtask

  task automatic idle();
    color_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    color_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int errs, lkmin, bad, cur;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hue_valid", hv1, 0);
    chk("reset_locked", lk1, 0);
    chk("reset_hue_idx", hi1, 0);

    // Full colour sweep.
    sweep_en = 1;
    for (int c = 0; c < 4096; c++) send(12'(c));
    idle();
    @(negedge clk);
    sweep_en = 0;
    chk("sweep_hits", hits, 90);
    bad = 0;
    for (int i = 0; i < 90; i++) if (seen[i] != 1) bad++;
    chk("sweep_unique", bad, 0);
    chk("map_FF0", lutmap[12'hFF0], 15);
    chk("map_0F0", lutmap[12'h0F0], 30);
    chk("map_00F", lutmap[12'h00F], 60);
    chk("map_F0F", lutmap[12'hF0F], 75);
    chk("map_F01", lutmap[12'hF01], 89);
    chk("map_123", lutmap[12'h123], -1);

    // Lock on the 5th sample, then run across the wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(gen(i));
      @(negedge clk);
      chk("lock_at_5th", lk1, (i == 4) ? 1 : 0);
    end
    errs = 0; lkmin = 1;
    for (int i = 5; i < 205; i++) begin
      send(gen(i));
      @(negedge clk);
      errs += int'(se1);
      lkmin &= int'(lk1);
    end
    chk("wrap_no_err", errs, 0);
    chk("wrap_locked", lkmin, 1);

    // Off-wheel while locked.
    send(12'h123);
    @(negedge clk);
    chk("off_err", se1, 1);
    chk("off_on_wheel", ow1, 0);
    chk("off_idx", hi1, 0);
    chk("off_locked", lk1, 0);
    send(12'hF00);
    @(negedge clk);
    chk("reacq_err", se1, 0);
    chk("reacq_on", ow1, 1);
    idle();
    @(negedge clk);
    chk("gap_valid", hv1, 0);

    // Jump 20 -> 40 while locked, re-lock after 4 good steps.
    for (int i = 1; i <= 20; i++) send(gen(i));
    @(negedge clk);
    chk("pre_jump_locked", lk1, 1);
    send(gen(40));
    @(negedge clk);
    chk("jump_err", se1, 1);
    chk("jump_locked", lk1, 0);
    for (int i = 41; i <= 44; i++) begin
      send(gen(i));
      @(negedge clk);
      chk("relock", lk1, (i == 44) ? 1 : 0);
    end

    // Holds: counted as good with ALLOW_HOLD=1, a break with ALLOW_HOLD=0.
    do_reset();
    send(12'hF00);
    send(12'hF00);
    @(negedge clk);
    chk("hold1_no_err", se1, 0);
    chk("hold0_err", se0, 1);
    send(12'hF00);
    send(gen(1));
    send(gen(2));
    @(negedge clk);
    chk("hold1_locked", lk1, 1);
    chk("hold0_not_locked", lk0, 0);

    // Reset with a coincident valid sample.
    color = gen(3); color_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; color_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid", hv1, 0);
    chk("rst_locked", lk1, 0);
    chk("rst_on_wheel", ow1, 0);
    chk("rst_idx", hi1, 0);
    for (int i = 0; i < 5; i++) begin
      send(gen(i));
      idle();
      idle();
    end
    @(negedge clk);
    chk("gaps_locked", lk1, 1);
    chk("gaps_idx", hi1, 4);
    chk("gaps_valid", hv1, 0);

    // Randomised mix of steps, holds, jumps, junk, gaps and resets.
    cur = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60) begin cur = (cur + 1) % 90; send(gen(cur)); end
      else if (r < 70) send(gen(cur));
      else if (r < 78) begin cur = int'($urandom_range(0, 89)); send(gen(cur)); end
      else if (r < 84) send(12'($urandom));
      else if (r < 96) idle();
      else begin
        reset = 1'b1;
        color_valid = 1'($urandom);
        color = 12'($urandom);
        @(posedge clk); #1;
        reset = 1'b0; color_valid = 1'b0;
      end
    end
    idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
